dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 = Memory stage LSU, port 1 = secondary master (debug/DMA).

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (port 0) and a secondary master (port 1).
// Optional BUSY-state timeout abort is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_req,
    input  logic              i_wr_en0,
    input  logic              i_wr_en1,
    input  logic [3:0]        i_sel0,
    input  logic [3:0]        i_sel1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_rvalid,
    output logic [1:0]        o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_wr_en,
    output logic [3:0]        o_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_addr_vld,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_d_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    logic              last_r;
    logic              owner_r;
    logic              busy_r;
    logic              addr_vld_r;
    logic              wr_en_r;
    logic [3:0]        sel_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic [1:0]        rvalid_r;
    logic [1:0]        err_r;

    logic [1:0]        gnt_s;
    logic              win_s;
    logic [1:0]        owner_mask_s;
    logic              done_s;
    logic              abort_s;

    // A non-positive timeout is meaningless; this empty block makes such a setting visible in elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_invalid_timeout_cycles
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_r;
`endif

    assign owner_mask_s = owner_r ? 2'b10 : 2'b01;

    // Winner selection: sole requester, else the port that was not served last; gated off in BUSY and reset.
    always_comb begin
        gnt_s = 2'b00;
        win_s = 1'b0;
        if ((state_r == ST_IDLE) && rst_n) begin
            case (i_req)
                2'b01:   begin win_s = 1'b0;    gnt_s = 2'b01; end
                2'b10:   begin win_s = 1'b1;    gnt_s = 2'b10; end
                2'b11:   begin win_s = ~last_r; gnt_s = last_r ? 2'b01 : 2'b10; end
                default: begin win_s = 1'b0;    gnt_s = 2'b00; end
            endcase
        end else begin
            gnt_s = 2'b00;
            win_s = 1'b0;
        end
    end

    // Completion decode: memory response wins over a timeout on the same cycle.
    always_comb begin
        done_s  = 1'b0;
        abort_s = 1'b0;
        if (state_r == ST_BUSY) begin
            done_s = i_d_valid;
`ifdef DMEM_ARB_TIMEOUT_EN
            abort_s = ~i_d_valid && (cnt_r == CNT_LAST);
`else
            abort_s = 1'b0;
`endif
        end else begin
            done_s  = 1'b0;
            abort_s = 1'b0;
        end
    end

    // Arbitration FSM with registered memory command and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            owner_r    <= 1'b0;
            busy_r     <= 1'b0;
            addr_vld_r <= 1'b0;
            wr_en_r    <= 1'b0;
            sel_r      <= 4'h0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            rvalid_r   <= 2'b00;
            err_r      <= 2'b00;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_r      <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rvalid_r <= 2'b00;
                    err_r    <= 2'b00;
                    if (|gnt_s) begin
                        state_r    <= ST_BUSY;
                        owner_r    <= win_s;
                        busy_r     <= 1'b1;
                        addr_vld_r <= 1'b1;
                        wr_en_r    <= win_s ? i_wr_en1 : i_wr_en0;
                        sel_r      <= win_s ? i_sel1   : i_sel0;
                        addr_r     <= win_s ? i_addr1  : i_addr0;
                        wdata_r    <= win_s ? i_wdata1 : i_wdata0;
`ifdef DMEM_ARB_TIMEOUT_EN
                        cnt_r      <= {CNT_W{1'b0}};
`endif
                    end
                end
                ST_BUSY: begin
                    if (done_s || abort_s) begin
                        state_r    <= ST_IDLE;
                        last_r     <= owner_r;
                        busy_r     <= 1'b0;
                        addr_vld_r <= 1'b0;
                        wr_en_r    <= 1'b0;
                        sel_r      <= 4'h0;
                        addr_r     <= {ADDR_W{1'b0}};
                        wdata_r    <= {DATA_W{1'b0}};
                        rvalid_r   <= owner_mask_s;
                        err_r      <= abort_s ? owner_mask_s : 2'b00;
                        rdata_r    <= (wr_en_r || abort_s) ? {DATA_W{1'b0}} : i_rdata;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = gnt_s;
    assign o_rvalid   = rvalid_r;
    assign o_err      = err_r;
    assign o_rdata    = rdata_r;
    assign o_busy     = busy_r;
    assign o_wr_en    = wr_en_r;
    assign o_sel      = sel_r;
    assign o_addr     = addr_r;
    assign o_addr_vld = addr_vld_r;
    assign o_wdata    = wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_req = 2'b00;
    logic        i_wr_en0 = 1'b0, i_wr_en1 = 1'b0;
    logic [3:0]  i_sel0 = 4'h0, i_sel1 = 4'h0;
    logic [31:0] i_addr0 = 32'h0, i_addr1 = 32'h0;
    logic [31:0] i_wdata0 = 32'h0, i_wdata1 = 32'h0;
    logic [31:0] i_rdata = 32'h0;
    logic        i_d_valid = 1'b0;
    logic [1:0]  o_gnt, o_rvalid, o_err;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic        o_busy, o_wr_en, o_addr_vld;
    logic [3:0]  o_sel;

    int cmps = 0;
    int errs = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req),
        .i_wr_en0(i_wr_en0), .i_wr_en1(i_wr_en1), .i_sel0(i_sel0), .i_sel1(i_sel1),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_err(o_err), .o_rdata(o_rdata),
        .o_busy(o_busy), .o_wr_en(o_wr_en), .o_sel(o_sel), .o_addr(o_addr),
        .o_addr_vld(o_addr_vld), .o_wdata(o_wdata), .i_rdata(i_rdata), .i_d_valid(i_d_valid)
    );

    always #5 clk = ~clk;

    wire [108:0] all_out = {o_gnt, o_rvalid, o_err, o_rdata, o_busy, o_wr_en, o_sel, o_addr, o_addr_vld, o_wdata};

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        cmps++; if (all_out !== 109'd0) begin errs++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_req = 2'b00;
            i_d_valid = i[0];
            i_rdata = $urandom;
            #1;
            cmps++; if (all_out !== 109'd0) begin errs++; $display("FAIL idle_outputs cyc=%0d got=%h exp=0", i, all_out); end
        end
        i_d_valid = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk);
        i_req = 2'b01; i_wr_en0 = 1'b0; i_sel0 = 4'hF; i_addr0 = 32'h100; i_wdata0 = 32'h0;
        #1;
        cmps++; if (o_gnt !== 2'b01) begin errs++; $display("FAIL load_gnt got=%b exp=01", o_gnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_req = 2'b10;
            i_d_valid = (i == 2);
            i_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            cmps++;
            if ({o_gnt, o_addr_vld, o_busy, o_wr_en, o_sel, o_addr, o_rvalid} !== {2'b00, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 2'b00}) begin
                errs++; $display("FAIL load_busy cyc=%0d got gnt=%b vld=%b addr=%h sel=%h exp gnt=00 vld=1 addr=100 sel=f", i, o_gnt, o_addr_vld, o_addr, o_sel);
            end
        end
        @(negedge clk);
        i_req = 2'b00; i_d_valid = 1'b0;
        #1;
        cmps++;
        if ({o_rvalid, o_err, o_rdata, o_addr_vld, o_gnt} !== {2'b01, 2'b00, 32'hDEADBEEF, 1'b0, 2'b00}) begin
            errs++; $display("FAIL load_done got rv=%b rdata=%h vld=%b exp rv=01 rdata=deadbeef vld=0", o_rvalid, o_rdata, o_addr_vld);
        end
        @(negedge clk);
        cmps++;
        if ({o_rvalid, o_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            errs++; $display("FAIL load_hold got rv=%b rdata=%h exp rv=00 rdata=deadbeef", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        i_req = 2'b10; i_wr_en1 = 1'b1; i_sel1 = 4'h3; i_addr1 = 32'h40; i_wdata1 = 32'h12345678;
        #1;
        cmps++; if (o_gnt !== 2'b10) begin errs++; $display("FAIL store_gnt got=%b exp=10", o_gnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            i_req = 2'b00;
            i_d_valid = (i == 1);
            i_rdata = 32'hFFFFFFFF;
            #1;
            cmps++;
            if ({o_addr_vld, o_wr_en, o_sel, o_addr, o_wdata} !== {1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678}) begin
                errs++; $display("FAIL store_busy cyc=%0d got we=%b sel=%h addr=%h wdata=%h exp we=1 sel=3 addr=40 wdata=12345678", i, o_wr_en, o_sel, o_addr, o_wdata);
            end
        end
        @(negedge clk);
        i_d_valid = 1'b0; i_wr_en1 = 1'b0;
        #1;
        cmps++;
        if ({o_rvalid, o_rdata, o_addr_vld, o_wr_en} !== {2'b10, 32'h0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL store_done got rv=%b rdata=%h exp rv=10 rdata=0", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_rd;
        int          prev_port;
        i_wr_en0 = 1'b0; i_addr0 = 32'h200; i_sel0 = 4'hF;
        i_wr_en1 = 1'b0; i_addr1 = 32'h300; i_sel1 = 4'hC;
        last_rd = 32'h0;
        prev_port = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            i_req = (k < 8) ? 2'b11 : 2'b00;
            i_d_valid = (k < 8);
            #1;
            if (k % 2 == 0) begin
                cmps++;
                if (o_gnt !== ((k < 8) ? (((k / 2) % 2) ? 2'b10 : 2'b01) : 2'b00)) begin
                    errs++; $display("FAIL b2b_gnt k=%0d got=%b", k, o_gnt);
                end
                if (k > 0) begin
                    cmps++;
                    if ({o_rvalid, o_rdata} !== {(prev_port == 1) ? 2'b10 : 2'b01, last_rd}) begin
                        errs++; $display("FAIL b2b_rvalid k=%0d got rv=%b rdata=%h exp port=%0d rdata=%h", k, o_rvalid, o_rdata, prev_port, last_rd);
                    end
                end
                prev_port = (k / 2) % 2;
            end else begin
                cmps++;
                if ({o_gnt, o_addr_vld, o_addr, o_rvalid} !== {2'b00, 1'b1, (prev_port == 1) ? 32'h300 : 32'h200, 2'b00}) begin
                    errs++; $display("FAIL b2b_busy k=%0d got gnt=%b vld=%b addr=%h", k, o_gnt, o_addr_vld, o_addr);
                end
                i_rdata = 32'hA5A50000 + k;
                last_rd = i_rdata;
            end
        end
        i_d_valid = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        i_req = 2'b01; i_wr_en0 = 1'b0; i_addr0 = 32'h80; i_sel0 = 4'hF;
        #1;
        cmps++; if (o_gnt !== 2'b01) begin errs++; $display("FAIL rmb_gnt got=%b exp=01", o_gnt); end
        @(negedge clk);
        i_req = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmps++; if (all_out !== 109'd0) begin errs++; $display("FAIL rmb_async got=%h exp=0", all_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmps++; if ({o_rvalid, o_addr_vld, o_busy} !== 4'b0000) begin errs++; $display("FAIL rmb_norv got rv=%b vld=%b", o_rvalid, o_addr_vld); end
        i_req = 2'b01; i_addr0 = 32'h84;
        #1;
        cmps++; if (o_gnt !== 2'b01) begin errs++; $display("FAIL rmb_regnt got=%b exp=01", o_gnt); end
        @(negedge clk);
        i_req = 2'b00; i_d_valid = 1'b1; i_rdata = 32'h0BADF00D;
        cmps++; if ({o_addr_vld, o_addr} !== {1'b1, 32'h84}) begin errs++; $display("FAIL rmb_busy got vld=%b addr=%h exp vld=1 addr=84", o_addr_vld, o_addr); end
        @(negedge clk);
        i_d_valid = 1'b0;
        cmps++; if ({o_rvalid, o_rdata, o_addr_vld} !== {2'b01, 32'h0BADF00D, 1'b0}) begin errs++; $display("FAIL rmb_done got rv=%b rdata=%h exp rv=01 rdata=0badf00d", o_rvalid, o_rdata); end
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            i_req = 2'b10; i_wr_en1 = 1'b0; i_addr1 = 32'h500; i_sel1 = 4'hF;
            #1;
            cmps++; if (o_gnt !== 2'b10) begin errs++; $display("FAIL to_gnt pass=%0d got=%b exp=10", pass, o_gnt); end
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                i_req = 2'b00;
                i_d_valid = (pass == 1) && (i == TO - 1);
                i_rdata = 32'h13572468;
                cmps++; if ({o_addr_vld, o_rvalid} !== {1'b1, 2'b00}) begin errs++; $display("FAIL to_busy pass=%0d cyc=%0d got vld=%b rv=%b", pass, i, o_addr_vld, o_rvalid); end
            end
            @(negedge clk);
            i_d_valid = 1'b0;
            cmps++;
            if ({o_rvalid, o_err, o_rdata} !== {2'b10, (pass == 0) ? 2'b10 : 2'b00, (pass == 0) ? 32'h0 : 32'h13572468}) begin
                errs++; $display("FAIL to_done pass=%0d got rv=%b err=%b rdata=%h", pass, o_rvalid, o_err, o_rdata);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0]  preq;
        logic        pwr [2];
        logic [3:0]  psel [2];
        logic [31:0] paddr [2];
        logic [31:0] pwdata [2];
        logic        m_busy, m_wr;
        logic [3:0]  m_sel;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [1:0]  m_rv, m_err, exp_gnt;
        int          m_owner, m_last, m_bcnt, win;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        preq = 2'b00; m_busy = 1'b0; m_wr = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        m_rdata = 32'h0; m_rv = 2'b00; m_err = 2'b00; m_owner = 0; m_last = 1; m_bcnt = 0;
        for (int p = 0; p < 2; p++) begin pwr[p] = 1'b0; psel[p] = 4'h0; paddr[p] = 32'h0; pwdata[p] = 32'h0; end
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cmps++;
            if ({o_rvalid, o_err, o_busy, o_addr_vld, o_rdata} !== {m_rv, m_err, m_busy, m_busy, m_rdata}) begin
                errs++; $display("FAIL rand_status cyc=%0d got rv=%b err=%b busy=%b vld=%b rdata=%h exp rv=%b err=%b busy=%b rdata=%h",
                                 n, o_rvalid, o_err, o_busy, o_addr_vld, o_rdata, m_rv, m_err, m_busy, m_rdata);
            end
            if (m_busy) begin
                cmps++;
                if ({o_wr_en, o_sel, o_addr, o_wdata} !== {m_wr, m_sel, m_addr, m_wdata}) begin
                    errs++; $display("FAIL rand_cmd cyc=%0d got we=%b sel=%h addr=%h wd=%h exp we=%b sel=%h addr=%h wd=%h",
                                     n, o_wr_en, o_sel, o_addr, o_wdata, m_wr, m_sel, m_addr, m_wdata);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!preq[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        preq[p] = 1'b1; pwr[p] = $urandom_range(0, 1) == 1;
                        psel[p] = 4'($urandom); paddr[p] = $urandom; pwdata[p] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    preq[p] = 1'b0;
                end
            end
            i_req = preq;
            i_wr_en0 = pwr[0]; i_sel0 = psel[0]; i_addr0 = paddr[0]; i_wdata0 = pwdata[0];
            i_wr_en1 = pwr[1]; i_sel1 = psel[1]; i_addr1 = paddr[1]; i_wdata1 = pwdata[1];
            i_d_valid = ($urandom_range(0, 2) == 0);
            i_rdata = $urandom;
            #1;
            win = -1;
            if (!m_busy) begin
                if (preq == 2'b11) win = 1 - m_last;
                else if (preq[0]) win = 0;
                else if (preq[1]) win = 1;
            end
            exp_gnt = 2'b00;
            if (win >= 0) exp_gnt[win] = 1'b1;
            cmps++;
            if (o_gnt !== exp_gnt) begin errs++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", n, o_gnt, exp_gnt); end
            m_rv = 2'b00; m_err = 2'b00;
            if (win >= 0) begin
                m_busy = 1'b1; m_owner = win; m_bcnt = 0;
                m_wr = pwr[win]; m_sel = psel[win]; m_addr = paddr[win]; m_wdata = pwdata[win];
                preq[win] = 1'b0;
            end else if (m_busy) begin
                m_bcnt++;
                if (i_d_valid) begin
                    m_rv[m_owner] = 1'b1; m_rdata = m_wr ? 32'h0 : i_rdata;
                    m_last = m_owner; m_busy = 1'b0;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (m_bcnt == TO) begin
                    m_rv[m_owner] = 1'b1; m_err[m_owner] = 1'b1; m_rdata = 32'h0;
                    m_last = m_owner; m_busy = 1'b0;
                end
`endif
            end
        end
        i_req = 2'b00; i_d_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
